// File: rtl/spi_multi_reg_slave.sv
// SPI mode-0 slave serving NCH word-wide channels in a contiguous address window.
// Reads snapshot a channel and shift it out MSB first; writes shift a word in and strobe it out.
module spi_multi_reg_slave #(
  parameter int NBIT        = 32,
  parameter int NCH         = 4,
  parameter int BASE_ADR    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   sclk,
  input  logic                                   mosi,
  input  logic                                   cs,
  output logic                                   miso,
  output logic                                   miso_oe,
  input  logic [NCH*NBIT-1:0]                    inport,
  output logic                                   rd_stb,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] rd_ch,
  output logic [NBIT-1:0]                        wr_data,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch,
  output logic                                   wr_stb,
  output logic                                   cmd_err,
  output logic                                   busy
);

  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CMAX = (NBIT > 8) ? NBIT : 8;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] CNT_CMD_LAST = CW'(7);
  localparam logic [CW-1:0] CNT_RD_LAST  = CW'(NBIT);
  localparam logic [CW-1:0] CNT_WR_LAST  = CW'(NBIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Synchronisers are deliberately not reset: a reset inside a frame must not
  // fabricate a cs falling edge once the chain refills with the real pin level.
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_d, cs_d;

  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
    sclk_d    <= sclk_sync[SYNC_STAGES-1];
    cs_d      <= cs_sync[SYNC_STAGES-1];
  end

  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, sclk_fall, cs_fall;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = cs_d & ~cs_s;

  logic [6:0]      cmd_sr;
  logic [NBIT-1:0] sr;
  logic [CW-1:0]   cnt;
  logic [CHW-1:0]  ch_q;
  logic            wr_pend;

  // Command decode looks at the byte as it will be after the current mosi bit.
  logic [7:0]      cmd_next;
  logic [7:0]      off;
  logic            in_win;
  logic [CHW-1:0]  ch_sel;
  logic [NBIT-1:0] word_sel;

  assign cmd_next = {cmd_sr, mosi_s};
  assign off      = {1'b0, cmd_next[6:0]} - 8'(BASE_ADR);
  assign in_win   = (off < 8'(NCH));
  assign ch_sel   = off[CHW-1:0];
  assign word_sel = inport[int'(ch_sel)*NBIT +: NBIT];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (cs_fall) state_d = S_CMD;
        S_CMD: begin
          if (sclk_rise && cnt == CNT_CMD_LAST) begin
            if (!in_win)         state_d = S_DONE;
            else if (cmd_next[7]) state_d = S_WRITE;
            else                 state_d = S_READ;
          end
        end
        S_READ:  if (sclk_fall && cnt == CNT_RD_LAST) state_d = S_DONE;
        S_WRITE: if (sclk_rise && cnt == CNT_WR_LAST) state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miso    <= 1'b0;
      miso_oe <= 1'b0;
      rd_stb  <= 1'b0;
      rd_ch   <= '0;
      wr_data <= '0;
      wr_ch   <= '0;
      wr_stb  <= 1'b0;
      cmd_err <= 1'b0;
      busy    <= 1'b0;
      cmd_sr  <= '0;
      sr      <= '0;
      cnt     <= '0;
      ch_q    <= '0;
      wr_pend <= 1'b0;
    end else begin
      rd_stb  <= 1'b0;
      wr_stb  <= 1'b0;
      cmd_err <= 1'b0;
      busy    <= ~cs_s;

      if (wr_pend) begin
        wr_data <= sr;
        wr_ch   <= ch_q;
        wr_stb  <= 1'b1;
        wr_pend <= 1'b0;
      end

      if (cs_s) begin
        miso    <= 1'b0;
        miso_oe <= 1'b0;
        cnt     <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cs_fall) begin
              // An sclk rise arriving with the cs edge is command bit 7.
              if (sclk_rise) begin
                cmd_sr <= cmd_next[6:0];
                cnt    <= CW'(1);
              end else begin
                cnt    <= '0;
              end
            end
          end
          S_CMD: begin
            if (sclk_rise) begin
              cmd_sr <= cmd_next[6:0];
              cnt    <= cnt + 1'b1;
              if (cnt == CNT_CMD_LAST) begin
                cnt <= '0;
                if (!in_win) begin
                  cmd_err <= 1'b1;
                end else begin
                  ch_q <= ch_sel;
                  if (!cmd_next[7]) begin
                    sr      <= word_sel;
                    miso    <= word_sel[NBIT-1];
                    miso_oe <= 1'b1;
                    rd_stb  <= 1'b1;
                    rd_ch   <= ch_sel;
                  end
                end
              end
            end
          end
          S_READ: begin
            // Fall 0 follows the command LSB and only counts; falls 1..NBIT-1
            // advance the word; fall NBIT releases the line.
            if (sclk_fall) begin
              cnt <= cnt + 1'b1;
              if (cnt == CNT_RD_LAST) begin
                miso    <= 1'b0;
                miso_oe <= 1'b0;
                cnt     <= '0;
              end else if (cnt != '0) begin
                sr   <= {sr[NBIT-2:0], 1'b0};
                miso <= sr[NBIT-2];
              end
            end
          end
          S_WRITE: begin
            if (sclk_rise) begin
              sr  <= {sr[NBIT-2:0], mosi_s};
              cnt <= cnt + 1'b1;
              if (cnt == CNT_WR_LAST) begin
                wr_pend <= 1'b1;
                cnt     <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
